// File: rtl/mul_arbiter.sv
// mul_arbiter
//   Round-robin scheduler that shares one signed n-bit multiplier between N
//   requesters. Each cycle at most one request is granted; the granted
//   operands are steered to the multiplier. A {valid, id} tag travels beside
//   the multiplier for p cycles. When the tag emerges, the truncated product
//   is returned on a registered response port together with the owner's index.
//
// Ports
//   Clock     in   rising-edge clock
//   nReset    in   asynchronous active-low reset
//   Req       in   [N]    request per requester (held until granted)
//   ReqA/B    in   [N*n]  operands; requester i owns bits [i*n +: n]
//   Hold      in   blocks every grant this cycle
//   Gnt       out  [N]    one-hot grant (combinational)
//   MulA/B    out  [n]    operands to the shared multiplier (0 when idle)
//   MulOut    in   [n]    multiplier product, valid p cycles after issue
//   RspValid  out  registered one-cycle response strobe
//   RspId     out  [IW]   owner of RspData
//   RspData   out  [n]    low n bits of the signed product
module mul_arbiter #(
  parameter int N = 4,
  parameter int n = 8,
  parameter int p = 1,
  localparam int IW = $clog2(N)
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic [N-1:0]    Req,
  input  logic [N*n-1:0]  ReqA,
  input  logic [N*n-1:0]  ReqB,
  input  logic            Hold,
  output logic [N-1:0]    Gnt,
  output logic [n-1:0]    MulA,
  output logic [n-1:0]    MulB,
  input  logic [n-1:0]    MulOut,
  output logic            RspValid,
  output logic [IW-1:0]   RspId,
  output logic [n-1:0]    RspData
);

  logic [IW-1:0] r_ptr;
  logic          w_gnt_vld;
  logic [IW-1:0] w_gnt_id;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;
  logic          w_tag_vld;
  logic [IW-1:0] w_tag_id;

  // Stage 0: grant search from the pointer, modulo N, plus operand steering
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_sum     = '0;
    w_cand    = '0;
    if (nReset && !Hold) begin
      for (int k = 0; k < N; k++) begin
        // one conditional subtract is enough: r_ptr < N and k < N
        w_sum = {1'b0, r_ptr} + (IW+1)'(k);
        if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
        w_cand = w_sum[IW-1:0];
        if (!w_gnt_vld && Req[w_cand]) begin
          w_gnt_vld = 1'b1;
          w_gnt_id  = w_cand;
        end
      end
    end
  end

  always_comb begin
    Gnt  = '0;
    MulA = '0;
    MulB = '0;
    if (w_gnt_vld) Gnt[w_gnt_id] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (Gnt[i]) begin
        MulA = ReqA[i*n +: n];
        MulB = ReqB[i*n +: n];
      end
    end
  end

  // A grant is always an acceptance: Gnt is only raised where Req is high.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_ptr <= '0;
    end else if (w_gnt_vld) begin
      r_ptr <= (w_gnt_id == IW'(N-1)) ? '0 : w_gnt_id + 1'b1;
    end
  end

  // Stage 1..p: tag pipeline shadowing the multiplier latency
  generate
    if (p == 0) begin : g_tag_comb
      assign w_tag_vld = w_gnt_vld;
      assign w_tag_id  = w_gnt_id;
    end else begin : g_tag_pipe
      logic [p-1:0]  r_tag_vld;
      logic [IW-1:0] r_tag_id [p];

      always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
          r_tag_vld <= '0;
        end else begin
          r_tag_vld[0] <= w_gnt_vld;
          for (int s = 1; s < p; s++) r_tag_vld[s] <= r_tag_vld[s-1];
        end
      end

      // ids are meaningless without their valid bit, so they carry no reset
      always_ff @(posedge Clock) begin
        r_tag_id[0] <= w_gnt_id;
        for (int s = 1; s < p; s++) r_tag_id[s] <= r_tag_id[s-1];
      end

      assign w_tag_vld = r_tag_vld[p-1];
      assign w_tag_id  = r_tag_id[p-1];
    end
  endgenerate

  // Response register: id/data hold their last value between strobes
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      RspValid <= 1'b0;
      RspId    <= '0;
      RspData  <= '0;
    end else begin
      RspValid <= w_tag_vld;
      if (w_tag_vld) begin
        RspId   <= w_tag_id;
        RspData <= MulOut;
      end
    end
  end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin scheduler that shares one signed `n`-bit multiplier (the `mult` primitive, combinational or pipelined) between `N` requesters. It grants one request per cycle and drives the shared multiplier's operands. It tracks which requester owns each in-flight product and returns the product with a requester ID on a registered response port. It sits between the picoMIPS execution units and the single multiplier instance.

## Interface

Parameters:
- `N`, 4: number of requesters (2..8).
- `n`, 8: operand/product width.
- `p`, 1: latency of the attached multiplier (0 = combinational, 1 = one register stage).

Ports (`IW` = $clog2(N)):
- `Clock`  in  1  single clock, rising edge.
- `nReset`  in  1  reset, asynchronous, active-low.
- `Req`  in  N  request per requester; held high with operands stable until granted.
- `ReqA`  in  N*n  operand A per requester; requester i owns bits [i*n +: n].
- `ReqB`  in  N*n  operand B per requester, same packing.
- `Hold`  in  1  suppresses all grants this cycle.
- `Gnt`  out  N  one-hot grant; combinational from `Req`, `Hold` and the priority pointer.
- `MulA`  out  n  operand A to the shared multiplier.
- `MulB`  out  n  operand B to the shared multiplier.
- `MulOut`  in  n  product from the multiplier, valid `p` cycles after issue.
- `RspValid`  out  1  registered response strobe, one cycle wide.
- `RspId`  out  IW  index of the requester that owns `RspData`.
- `RspData`  out  n  low `n` bits of signed `A*B`.

## Operation

- **Priority pointer.** `Ptr` (IW bits) holds the highest-priority index. The grant search runs `Ptr`, `Ptr+1`, … modulo `N`.
- **Grant.** `Gnt[i]` goes high for the first i in search order with `Req[i]` high. `Gnt` is all-zero if `Hold` is high, no `Req` is high, or `nReset` is low.
- **Acceptance.** A request is accepted on a rising edge where `Req[i] & Gnt[i]`. The requester may drop or change `Req[i]` and operands in the following cycle.
- **Pointer update.** On acceptance of i, `Ptr <= (i+1) mod N`. Otherwise `Ptr` holds.
- **Operand drive.** `MulA`/`MulB` show the granted requester's operands in the grant cycle. They are 0 when there is no grant.
- **Tag pipeline.** A tag pipeline of depth `p` carries {valid, id} alongside the multiplier.
  - When `p = 0`, the tag is the current grant.
  - When `p = 1`, a single register stage holds the tag.
- **Response capture.** When the tag at the multiplier output is valid, the block registers `RspValid <= 1`, `RspId <= tag id`, and `RspData <= MulOut`. Otherwise `RspValid <= 0`, and `RspId`/`RspData` hold their last values.
- **Arithmetic.** Operands are two's complement. The product is truncated to the low `n` bits with no saturation and no overflow flag.
- **Starvation bound.** While `Hold` is low, any held `Req[i]` is granted within `N` cycles.

## Timing

- **Reset values.** `Ptr=0`, tag pipeline invalid, `RspValid=0`, `RspId=0`, `RspData=0`. `Gnt`, `MulA` and `MulB` are 0 while `nReset` is low.
- **Latency.** With acceptance at edge k, `RspValid` is high in the cycle after edge k+p, i.e. `p+1` cycles after the grant cycle.
- **Throughput.** One acceptance per cycle. Back-to-back grants produce back-to-back responses in grant order.
- **Hold.** Blocks new grants only. In-flight products still emerge on schedule.
- **Single requester.** The same requester is re-granted every cycle while it is the only one requesting.
- **Pointer wrap.** Granting index `N-1` sets `Ptr` to 0.
- **Reset mid-operation.** In-flight tags are discarded, so no `RspValid` follows reset release for pre-reset grants. `Ptr` returns to 0.
- **Non-compliant requester.** `Req` dropped before its grant is legal; the request is simply never accepted. Operand changes while `Req` is high and not granted are ignored.

## Test plan

- **Basic product.** Reset, `p=1`; `Req=0001`, `ReqA[0]=3`, `ReqB[0]=-5` → `Gnt=0001` in cycle 0; `RspValid` in cycle 2 with `RspId=0`, `RspData=0xF1` (-15).
- **Round-robin fairness.** All four `Req` held high for 8 cycles → `Gnt` sequence 0001,0010,0100,1000,0001,… and `RspId` sequence 0,1,2,3,0,… lagging by 2 cycles.
- **Truncation and wrap.** Requester 2 gives A=16, B=16 → `RspData=0x00`; then A=-128, B=-1 → `RspData=0x80`. `Ptr` moves to 3 after each grant.
- **Hold.** `Hold=1` for 3 cycles with `Req=1010` → `Gnt=0`, `MulA=MulB=0`, and responses already in flight still appear. After release, grant order is 1 then 3.
- **Reset mid-flight.** Grant requester 3, then assert `nReset` low before the response → `RspValid` stays 0 through and after reset, `Ptr=0`. The next `Req=1001` grants index 0 first.
- **Combinational multiplier.** `p=0`, back-to-back grants to requesters 1 and 2 → responses in consecutive cycles, each 1 cycle after its grant.
